// File: rtl/jtag_tap_oversampled.sv
// jtag_tap_oversampled: IEEE 1149.1 TAP controller clocked by the system clock, oversampling TCK.
// Provides IDCODE, BYPASS and one user DR with parallel capture/update handshakes.
// Optional build macro: JTAG_TAP_TCK_FILTER_EN adds a 3-sample TCK glitch filter (+2 clocks edge latency).
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   jtag_TCK/TMS/TDI      JTAG pins (asynchronous, synchronized internally)
//   jtag_TRSTn            JTAG test reset, active-low
//   jtag_TDO_data/driven  serial data out and its output enable
//   ir_value              current instruction (registered)
//   dr_capture_data/dr_capture  parallel value loaded in Capture-DR / 1-clock capture pulse
//   dr_update_data/dr_update    value shifted into the user DR / 1-clock update pulse
module jtag_tap_oversampled #(
    parameter int                  IR_WIDTH     = 5,
    parameter logic [31:0]         IDCODE_VALUE = 32'h00000001,
    parameter int                  DR_WIDTH     = 41,
    parameter logic [IR_WIDTH-1:0] USER_IR      = 5'h11,
    parameter int                  SYNC_STAGES  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jtag_TCK,
    input  logic                jtag_TMS,
    input  logic                jtag_TDI,
    input  logic                jtag_TRSTn,
    output logic                jtag_TDO_data,
    output logic                jtag_TDO_driven,
    output logic [IR_WIDTH-1:0] ir_value,
    input  logic [DR_WIDTH-1:0] dr_capture_data,
    output logic                dr_capture,
    output logic [DR_WIDTH-1:0] dr_update_data,
    output logic                dr_update
);
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } state_t;

    logic [SYNC_STAGES-1:0][3:0] pin_sync_q;
    logic                        tck_raw, tck_s, tms_s, tdi_s, trst_n_s;
    logic                        tck_prev_q, rise, fall;
    state_t                      state_q, state_d;
    logic [IR_WIDTH-1:0]         ir_q, ir_shift_q;
    logic [31:0]                 id_shift_q;
    logic [DR_WIDTH-1:0]         user_shift_q, dr_update_data_q;
    logic                        byp_q, tdo_data_q, tdo_driven_q, dr_capture_q, dr_update_q;
    logic                        sel_id, sel_user, dr_lsb;

    always_ff @(posedge clock)
        pin_sync_q <= {pin_sync_q[SYNC_STAGES-2:0], {jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn}};

    assign {tck_raw, tms_s, tdi_s, trst_n_s} = pin_sync_q[SYNC_STAGES-1];

`ifdef JTAG_TAP_TCK_FILTER_EN
    logic [1:0] tck_hist_q;
    logic       tck_filt_q;
    // The filtered level only moves once three consecutive synced samples agree,
    // so TCK pulses of one or two clocks never reach the edge detector.
    assign tck_s = (tck_raw & tck_hist_q[0] & tck_hist_q[1]) ? 1'b1 :
                   (!tck_raw & !tck_hist_q[0] & !tck_hist_q[1]) ? 1'b0 : tck_filt_q;
    always_ff @(posedge clock) begin
        tck_hist_q <= {tck_hist_q[0], tck_raw};
        tck_filt_q <= tck_s;
    end
`else
    assign tck_s = tck_raw;
`endif

    assign rise     = tck_s & ~tck_prev_q;
    assign fall     = ~tck_s & tck_prev_q;
    assign sel_id   = ir_q == IR_WIDTH'(1);
    assign sel_user = ir_q == USER_IR;
    assign dr_lsb   = sel_id ? id_shift_q[0] : sel_user ? user_shift_q[0] : byp_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms_s ? TLR    : RTI;
            RTI:      state_d = tms_s ? SEL_DR : RTI;
            SEL_DR:   state_d = tms_s ? SEL_IR : CAP_DR;
            CAP_DR:   state_d = tms_s ? EX1_DR : SH_DR;
            SH_DR:    state_d = tms_s ? EX1_DR : SH_DR;
            EX1_DR:   state_d = tms_s ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_d = tms_s ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_d = tms_s ? UPD_DR : SH_DR;
            UPD_DR:   state_d = tms_s ? SEL_DR : RTI;
            SEL_IR:   state_d = tms_s ? TLR    : CAP_IR;
            CAP_IR:   state_d = tms_s ? EX1_IR : SH_IR;
            SH_IR:    state_d = tms_s ? EX1_IR : SH_IR;
            EX1_IR:   state_d = tms_s ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_d = tms_s ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_d = tms_s ? UPD_IR : SH_IR;
            UPD_IR:   state_d = tms_s ? SEL_DR : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Actions key off the state held before the rise, matching TCK-rising-edge semantics.
    always_ff @(posedge clock) begin
        tck_prev_q   <= tck_s;
        dr_capture_q <= 1'b0;
        dr_update_q  <= 1'b0;
        if (reset || !trst_n_s) begin
            state_q      <= TLR;
            ir_q         <= IR_WIDTH'(1);
            tdo_data_q   <= 1'b0;
            tdo_driven_q <= 1'b0;
            if (reset)
                dr_update_data_q <= '0;
        end else if (rise) begin
            state_q <= state_d;
            case (state_q)
                CAP_IR: ir_shift_q <= IR_WIDTH'(1);
                SH_IR:  ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
                UPD_IR: ir_q <= ir_shift_q;
                CAP_DR: begin
                    id_shift_q <= IDCODE_VALUE;
                    byp_q      <= 1'b0;
                    if (sel_user) begin
                        user_shift_q <= dr_capture_data;
                        dr_capture_q <= 1'b1;
                    end
                end
                SH_DR: begin
                    if (sel_id)
                        id_shift_q <= {tdi_s, id_shift_q[31:1]};
                    else if (sel_user)
                        user_shift_q <= {tdi_s, user_shift_q[DR_WIDTH-1:1]};
                    else
                        byp_q <= tdi_s;
                end
                UPD_DR: begin
                    if (sel_user) begin
                        dr_update_data_q <= user_shift_q;
                        dr_update_q      <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Reaching Test-Logic-Reset through TMS reselects IDCODE.
            if (state_d == TLR)
                ir_q <= IR_WIDTH'(1);
        end else if (fall) begin
            tdo_driven_q <= state_q == SH_IR || state_q == SH_DR;
            tdo_data_q   <= state_q == SH_IR ? ir_shift_q[0] : state_q == SH_DR ? dr_lsb : 1'b0;
        end
    end

    assign jtag_TDO_data   = tdo_data_q;
    assign jtag_TDO_driven = tdo_driven_q;
    assign ir_value        = ir_q;
    assign dr_capture      = dr_capture_q;
    assign dr_update_data  = dr_update_data_q;
    assign dr_update       = dr_update_q;
endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// tb_jtag_tap_oversampled: self-checking bench for jtag_tap_oversampled (vector table, corner sequences, random scans vs. transaction model).
module tb_jtag_tap_oversampled;
    localparam int H = 7;
    localparam logic [4:0] USER = 5'h11;

    logic        clock = 1'b0;
    logic        reset, jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic        jtag_TDO_data, jtag_TDO_driven, dr_capture, dr_update;
    logic [4:0]  ir_value;
    logic [40:0] dr_capture_data, dr_update_data;

    int total = 0;
    int bad = 0;
    int cap_cnt = 0;
    int upd_cnt = 0;
    int upd_hi = 0;
    logic upd_prev = 1'b0;

    jtag_tap_oversampled dut (
        .clock(clock), .reset(reset),
        .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
        .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven), .ir_value(ir_value),
        .dr_capture_data(dr_capture_data), .dr_capture(dr_capture),
        .dr_update_data(dr_update_data), .dr_update(dr_update)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (dr_capture) cap_cnt <= cap_cnt + 1;
        if (dr_update) upd_hi <= upd_hi + 1;
        if (dr_update && !upd_prev) upd_cnt <= upd_cnt + 1;
        upd_prev <= dr_update;
    end

    typedef struct {
        logic [4:0]   ir;
        int           n;
        logic [63:0]  data;
        logic [40:0]  cap;
        logic [127:0] exp_tdo;
        logic [40:0]  exp_upd;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One TCK period; returns TDO as presented by the previous falling edge.
    task automatic tck_bit(input logic tms, input logic tdi, output logic tdo, output logic drv);
        jtag_TMS = tms;
        jtag_TDI = tdi;
        tdo = jtag_TDO_data;
        drv = jtag_TDO_driven;
        jtag_TCK = 1'b1;
        wait_clk(H);
        jtag_TCK = 1'b0;
        wait_clk(H);
    endtask

    task automatic scan_ir(input logic [4:0] v);
        logic t, d, ok;
        logic [4:0] got;
        ok = 1'b1;
        got = '0;
        tck_bit(1, 0, t, d);
        tck_bit(1, 0, t, d);
        tck_bit(0, 0, t, d);
        tck_bit(0, 0, t, d);
        if (d) ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tck_bit(i == 4, v[i], t, d);
            got[i] = t;
            if (!d) ok = 1'b0;
        end
        tck_bit(1, 0, t, d);
        if (d) ok = 1'b0;
        tck_bit(0, 0, t, d);
        check("ir_capture_bits", 128'(got), 128'(5'b00001));
        check("ir_tdo_driven", 128'(ok), 128'(1));
    endtask

    task automatic scan_dr(input int n, input logic [63:0] data, output logic [127:0] tdo_v, output logic drv_ok);
        logic t, d;
        tdo_v = '0;
        drv_ok = 1'b1;
        tck_bit(1, 0, t, d);
        tck_bit(0, 0, t, d);
        tck_bit(0, 0, t, d);
        if (d) drv_ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            tck_bit(i == n - 1, data[i], t, d);
            tdo_v[i] = t;
            if (!d) drv_ok = 1'b0;
        end
        tck_bit(1, 0, t, d);
        if (d) drv_ok = 1'b0;
        tck_bit(0, 0, t, d);
    endtask

    task automatic run_op(input string name, input logic [4:0] ir, input int n, input logic [63:0] data,
                          input logic [40:0] cap, input logic [127:0] exp_tdo, input logic [40:0] exp_upd);
        logic [127:0] got, mask;
        logic drv_ok;
        int c0, u0, h0, pulses;
        scan_ir(ir);
        check({name, "_ir_value"}, 128'(ir_value), 128'(ir));
        dr_capture_data = cap;
        c0 = cap_cnt;
        u0 = upd_cnt;
        h0 = upd_hi;
        scan_dr(n, data, got, drv_ok);
        mask = (128'd1 << n) - 128'd1;
        pulses = (ir == USER) ? 1 : 0;
        check({name, "_tdo"}, got & mask, exp_tdo & mask);
        check({name, "_driven"}, 128'(drv_ok), 128'(1));
        check({name, "_capture_pulses"}, 128'(cap_cnt - c0), 128'(pulses));
        check({name, "_update_pulses"}, 128'(upd_cnt - u0), 128'(pulses));
        check({name, "_update_width"}, 128'(upd_hi - h0), 128'(pulses));
        check({name, "_update_data"}, 128'(dr_update_data), 128'(exp_upd));
    endtask

    // Transaction-level model: the serial stream seen on TDO is the captured value
    // followed by the bits shifted in; the DR left behind is that stream shifted by n.
    function automatic logic [127:0] model_stream(input logic [4:0] ir, input logic [63:0] data, input logic [40:0] cap);
        logic [127:0] d;
        d = {64'b0, data};
        if (ir == 5'h01) return (d << 32) | 128'h1;
        if (ir == USER) return (d << 41) | {87'b0, cap};
        return d << 1;
    endfunction

    initial begin
        logic t, d, drv_ok;
        logic [127:0] got, stream, shifted;
        logic [40:0] model_upd;
        logic [4:0] rir;
        int n;
        vecs[0] = '{5'h01, 32, 64'h0, 41'h0, 128'h0000_0001, 41'h0};
        vecs[1] = '{5'h1F, 8, 64'hA5, 41'h0, 128'h4A, 41'h0};
        vecs[2] = '{USER, 41, 64'h0AA_5555_FFFF, 41'h123_4567_89AB, 128'h123_4567_89AB, 41'h0AA_5555_FFFF};
        vecs[3] = '{5'h01, 40, 64'hFF, 41'h0, 128'hFF_0000_0001, 41'h0AA_5555_FFFF};
        vecs[4] = '{5'h00, 4, 64'hB, 41'h0, 128'h6, 41'h0AA_5555_FFFF};
        vecs[5] = '{USER, 43, 64'h400_0000_0003, 41'h0, 128'h600_0000_0000, 41'h100_0000_0000};
        vecs[6] = '{5'h1F, 3, 64'h7, 41'h0, 128'h6, 41'h100_0000_0000};

        reset = 1'b1;
        jtag_TCK = 1'b0;
        jtag_TMS = 1'b1;
        jtag_TDI = 1'b0;
        jtag_TRSTn = 1'b1;
        dr_capture_data = '0;
        wait_clk(6);
        reset = 1'b0;
        wait_clk(2);
        check("reset_ir_value", 128'(ir_value), 128'(1));
        check("reset_tdo_data", 128'(jtag_TDO_data), 128'(0));
        check("reset_tdo_driven", 128'(jtag_TDO_driven), 128'(0));
        check("reset_update_data", 128'(dr_update_data), 128'(0));
        check("reset_pulses", 128'({dr_capture, dr_update}), 128'(0));

        for (int i = 0; i < 5; i++) tck_bit(1, 0, t, d);
        tck_bit(0, 0, t, d);
        check("rti_ir_value", 128'(ir_value), 128'(1));
        check("rti_tdo_driven", 128'(jtag_TDO_driven), 128'(0));

        for (int i = 0; i < 7; i++)
            run_op($sformatf("vec%0d", i), vecs[i].ir, vecs[i].n, vecs[i].data, vecs[i].cap, vecs[i].exp_tdo, vecs[i].exp_upd);

        // Five TMS=1 rises from Shift-IR reach Test-Logic-Reset and reselect IDCODE.
        scan_ir(USER);
        tck_bit(1, 0, t, d);
        tck_bit(1, 0, t, d);
        tck_bit(0, 0, t, d);
        tck_bit(0, 0, t, d);
        for (int i = 0; i < 5; i++) tck_bit(1, 0, t, d);
        check("tms5_ir_value", 128'(ir_value), 128'(1));
        tck_bit(0, 0, t, d);
        scan_dr(32, 64'h0, got, drv_ok);
        check("tms5_idcode", got & 128'hFFFF_FFFF, 128'h1);

        // TRSTn pulse in the middle of a user DR shift.
        scan_ir(USER);
        dr_capture_data = 41'h1FF_FFFF_FFFF;
        n = upd_cnt;
        tck_bit(1, 0, t, d);
        tck_bit(0, 0, t, d);
        tck_bit(0, 0, t, d);
        for (int i = 0; i < 3; i++) tck_bit(0, 1, t, d);
        jtag_TRSTn = 1'b0;
        wait_clk(2 * H);
        jtag_TRSTn = 1'b1;
        wait_clk(4);
        check("trst_ir_value", 128'(ir_value), 128'(1));
        check("trst_tdo_driven", 128'(jtag_TDO_driven), 128'(0));
        check("trst_no_update", 128'(upd_cnt - n), 128'(0));
        check("trst_keeps_update_data", 128'(dr_update_data), 128'(41'h100_0000_0000));
        tck_bit(0, 0, t, d);
        scan_dr(32, 64'h0, got, drv_ok);
        check("trst_idcode", got & 128'hFFFF_FFFF, 128'h1);

        // System reset in the middle of a user DR shift.
        scan_ir(USER);
        n = upd_cnt;
        tck_bit(1, 0, t, d);
        tck_bit(0, 0, t, d);
        tck_bit(0, 0, t, d);
        tck_bit(0, 1, t, d);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        wait_clk(2);
        check("rst_ir_value", 128'(ir_value), 128'(1));
        check("rst_tdo_driven", 128'(jtag_TDO_driven), 128'(0));
        check("rst_update_data", 128'(dr_update_data), 128'(0));
        check("rst_no_update", 128'(upd_cnt - n), 128'(0));
        tck_bit(0, 0, t, d);

        // One-clock TCK glitch while shifting IDCODE (bit0=1, bit1=0).
        scan_ir(5'h01);
        tck_bit(1, 0, t, d);
        tck_bit(0, 0, t, d);
        tck_bit(0, 0, t, d);
        check("glitch_tdo_before", 128'(jtag_TDO_data), 128'(1));
        jtag_TDI = 1'b0;
        jtag_TCK = 1'b1;
        wait_clk(1);
        jtag_TCK = 1'b0;
        wait_clk(2 * H);
`ifdef JTAG_TAP_TCK_FILTER_EN
        check("glitch_tdo_after", 128'(jtag_TDO_data), 128'(1));
`else
        check("glitch_tdo_after", 128'(jtag_TDO_data), 128'(0));
`endif
        tck_bit(1, 0, t, d);
        tck_bit(1, 0, t, d);
        tck_bit(0, 0, t, d);

        model_upd = '0;
        for (int k = 0; k < 16; k++) begin
            case ($urandom_range(0, 3))
                0: rir = 5'h01;
                1: rir = USER;
                default: rir = 5'($urandom);
            endcase
            n = $urandom_range(1, 60);
            got = {64'b0, $urandom, $urandom};
            dr_capture_data = {$urandom_range(0, 511), $urandom};
            stream = model_stream(rir, got[63:0], dr_capture_data);
            shifted = stream >> n;
            if (rir == USER) model_upd = shifted[40:0];
            run_op($sformatf("rnd%0d", k), rir, n, got[63:0], dr_capture_data, stream, model_upd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
